// File: rtl/spi_pkg.sv
// SPI burst slave shared definitions.
// FSM encoding, header bit positions and parameter limits.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_TURN,
    S_WDATA,
    S_RDATA
  } spi_state_t;

  localparam int RW_BIT  = 0;
  localparam int INC_BIT = 1;

  localparam int ADDR_W_MIN = 1;
  localparam int ADDR_W_MAX = 16;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 32;
  localparam int DUMMY_MIN  = 1;
  localparam int DUMMY_MAX  = 7;

  // Widest count is a data word.
  localparam int CNT_W = $clog2(DATA_W_MAX);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int clamp(
    input int v,
    input int lo,
    input int hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// SPI read-data shifter, MSB first.
// Shifts on SCLK rise, launches MISO on SCLK fall.
module spi_shift_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              SCLK,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              MISO,
  output logic              MISO_enable
);

  logic [DATA_W-1:0] sh;
  logic              vld;

  // Parallel load a word, or shift it one bit toward the MSB.
  always_ff @(posedge SCLK) begin
    if (!rst_n || clear) begin
      sh  <= '0;
      vld <= 1'b0;
    end else if (load) begin
      sh  <= load_data;
      vld <= 1'b1;
    end else if (shift) begin
      sh <= {sh[DATA_W-2:0], 1'b0};
    end
  end

  // Half-cycle launch so the master sees stable data at its rise.
  always_ff @(negedge SCLK) begin
    MISO_enable <= vld;
    MISO        <= vld & sh[DATA_W-1];
  end

endmodule

// File: rtl/spi_burst_slave.sv
// SPI register-access slave with burst read/write.
// Header: RW, INC, address; then back-to-back data words.
module spi_burst_slave
  import spi_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int DUMMY_CYC = 2
) (
  input  logic              SCLK,
  input  logic              rst_n,
  input  logic              CSN,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] reg_read_data,
  output logic              MISO,
  output logic              MISO_enable,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              reg_write_enable,
  output logic              reg_read_enable,
  output logic              frame_abort
);

  localparam int AW_C = clamp(ADDR_W, ADDR_W_MIN, ADDR_W_MAX);
  localparam int DW_C = clamp(DATA_W, DATA_W_MIN, DATA_W_MAX);
  localparam int DC_C = clamp(DUMMY_CYC, DUMMY_MIN, DUMMY_MAX);

  localparam cnt_t ADDR_LAST = cnt_t'(AW_C - 1);
  localparam cnt_t TURN_LAST = cnt_t'(DC_C - 1);
  localparam cnt_t WORD_LAST = cnt_t'(DW_C - 1);
  // Next read issued two edges ahead of the last bit.
  localparam cnt_t PREF_AT   = cnt_t'(DW_C - 3);

  spi_state_t        state;
  cnt_t              bit_cnt;
  logic [1:0]        hdr;
  logic              first_wd;
  logic [ADDR_W-1:0] addr_sh;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] data_nxt;
  logic              word_end;
  logic              partial;
  logic              tx_load;
  logic              tx_shift;

  // Shift-in values and TX shifter control for this edge.
  always_comb begin
    addr_nxt = ADDR_W'({addr_sh, MOSI});
    data_nxt = DATA_W'({data_sh, MOSI});
    word_end = (bit_cnt == WORD_LAST);
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    if (!CSN) begin
      if (state == S_TURN && bit_cnt == TURN_LAST) begin
        tx_load = 1'b1;
      end
      if (state == S_RDATA) begin
        tx_load  = word_end;
        tx_shift = !word_end;
      end
    end
  end

  // A deselect here would cut a header or a word short.
  always_comb begin
    partial = 1'b0;
    case (state)
      S_CMD, S_ADDR, S_TURN: partial = 1'b1;
      S_WDATA, S_RDATA:      partial = (bit_cnt != '0);
      default:               partial = 1'b0;
    endcase
  end

  // Frame FSM with registered strobes and address.
  always_ff @(posedge SCLK) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      bit_cnt          <= '0;
      hdr              <= '0;
      first_wd         <= 1'b0;
      addr_sh          <= '0;
      data_sh          <= '0;
      reg_addr         <= '0;
      reg_write_data   <= '0;
      reg_write_enable <= 1'b0;
      reg_read_enable  <= 1'b0;
      frame_abort      <= 1'b0;
    end else begin
      reg_write_enable <= 1'b0;
      reg_read_enable  <= 1'b0;
      frame_abort      <= 1'b0;
      if (CSN) begin
        state       <= S_IDLE;
        bit_cnt     <= '0;
        frame_abort <= partial;
      end else begin
        unique case (state)
          S_IDLE: begin
            hdr[RW_BIT] <= MOSI;
            state       <= S_CMD;
          end
          S_CMD: begin
            hdr[INC_BIT] <= MOSI;
            bit_cnt      <= '0;
            state        <= S_ADDR;
          end
          S_ADDR: begin
            addr_sh <= addr_nxt;
            bit_cnt <= bit_cnt + cnt_t'(1);
            if (bit_cnt == ADDR_LAST) begin
              reg_addr <= addr_nxt;
              bit_cnt  <= '0;
              first_wd <= 1'b1;
              if (hdr[RW_BIT]) begin
                state <= S_WDATA;
              end else begin
                state           <= S_TURN;
                reg_read_enable <= 1'b1;
              end
            end
          end
          S_TURN: begin
            bit_cnt <= bit_cnt + cnt_t'(1);
            if (bit_cnt == TURN_LAST) begin
              bit_cnt <= '0;
              state   <= S_RDATA;
            end
          end
          S_WDATA: begin
            data_sh <= data_nxt;
            bit_cnt <= bit_cnt + cnt_t'(1);
            if (word_end) begin
              bit_cnt          <= '0;
              first_wd         <= 1'b0;
              reg_write_data   <= data_nxt;
              reg_write_enable <= 1'b1;
              // Address steps with the strobe of every word after the first.
              if (hdr[INC_BIT] && !first_wd) begin
                reg_addr <= reg_addr + ADDR_W'(1);
              end
            end
          end
          S_RDATA: begin
            bit_cnt <= bit_cnt + cnt_t'(1);
            if (bit_cnt == PREF_AT) begin
              reg_read_enable <= 1'b1;
              if (hdr[INC_BIT]) begin
                reg_addr <= reg_addr + ADDR_W'(1);
              end
            end
            if (word_end) begin
              bit_cnt <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  spi_shift_tx #(
    .DATA_W(DATA_W)
  ) u_tx (
    .SCLK       (SCLK),
    .rst_n      (rst_n),
    .clear      (CSN),
    .load       (tx_load),
    .shift      (tx_shift),
    .load_data  (reg_read_data),
    .MISO       (MISO),
    .MISO_enable(MISO_enable)
  );

endmodule

// File: tb/tb_spi_burst_slave.sv
// Scoreboard bench for spi_burst_slave.
// Stimulus pushes expected events; a monitor pops and compares.
module tb_spi_burst_slave;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DC = 2;

  logic          SCLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          CSN = 1'b1;
  logic          MOSI = 1'b0;
  logic [DW-1:0] reg_read_data = '0;
  logic          MISO;
  logic          MISO_enable;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_write_data;
  logic          reg_write_enable;
  logic          reg_read_enable;
  logic          frame_abort;

  int tests = 0;
  int fails = 0;
  int frame_k = 0;

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t  wq[$];
  ev_t  rq[$];
  ev_t  mq[$];
  int   aq[$];
  logic [15:0] mem [256];

  spi_burst_slave #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DUMMY_CYC(DC)
  ) dut (
    .SCLK            (SCLK),
    .rst_n           (rst_n),
    .CSN             (CSN),
    .MOSI            (MOSI),
    .reg_read_data   (reg_read_data),
    .MISO            (MISO),
    .MISO_enable     (MISO_enable),
    .reg_addr        (reg_addr),
    .reg_write_data  (reg_write_data),
    .reg_write_enable(reg_write_enable),
    .reg_read_enable (reg_read_enable),
    .frame_abort     (frame_abort)
  );

  always #5 SCLK = ~SCLK;

  // Register file model: data valid the cycle after the strobe.
  always @(posedge SCLK) begin
    if (reg_read_enable) reg_read_data <= mem[reg_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (k=%0d)", nm, act, exp, frame_k);
    end
  endtask

  task automatic miss(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected event want none (k=%0d)", nm, frame_k);
  endtask

  initial begin : mon
    ev_t e;
    int  ak;
    forever begin
      @(negedge SCLK);
      #2;
      if (reg_write_enable && reg_read_enable) miss("strobe_excl");
      if (reg_write_enable) begin
        if (wq.size() == 0) miss("wr_strobe");
        else begin
          e = wq.pop_front();
          chk("wr_k", frame_k, e.k);
          chk("wr_addr", 32'(reg_addr), 32'(e.a));
          chk("wr_data", 32'(reg_write_data), 32'(e.d));
        end
      end
      if (reg_read_enable) begin
        if (rq.size() == 0) miss("rd_strobe");
        else begin
          e = rq.pop_front();
          chk("rd_k", frame_k, e.k);
          chk("rd_addr", 32'(reg_addr), 32'(e.a));
        end
      end
      if (!MISO_enable) begin
        if (MISO) miss("miso_idle");
      end else if (!CSN) begin
        if (mq.size() == 0) miss("miso_bit");
        else begin
          e = mq.pop_front();
          chk("miso_k", frame_k, e.k);
          chk("miso_bit", 32'(MISO), 32'(e.d));
        end
      end
      if (frame_abort) begin
        if (aq.size() == 0) miss("abort");
        else begin
          ak = aq.pop_front();
          chk("abort_k", frame_k, ak);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic bit_out(input logic b, input int k);
    @(negedge SCLK);
    CSN = 1'b0;
    MOSI = b;
    frame_k = k;
    @(posedge SCLK);
  endtask

  task automatic hdr(input logic rw, input logic inc, input logic [7:0] a);
    bit_out(rw, 0);
    bit_out(inc, 1);
    for (int i = 0; i < 8; i++) bit_out(a[7-i], 2 + i);
  endtask

  task automatic stop(input int k);
    @(negedge SCLK);
    CSN = 1'b1;
    MOSI = 1'b0;
    frame_k = k;
    @(posedge SCLK);
    @(negedge SCLK);
    frame_k++;
    #2;
    chk("en_off", 32'(MISO_enable), 32'd0);
    repeat (2) begin
      @(negedge SCLK);
      frame_k++;
    end
  endtask

  task automatic wr_frame(input logic inc, input logic [7:0] a,
                          input logic [47:0] ws, input int nbits);
    hdr(1'b1, inc, a);
    for (int b = 0; b < nbits; b++) bit_out(ws[47-b], 10 + b);
    stop(10 + nbits);
  endtask

  task automatic rd_frame(input logic inc, input logic [7:0] a, input int n);
    hdr(1'b0, inc, a);
    for (int k = 10; k < 10 + n; k++) bit_out(1'b0, k);
    stop(10 + n);
  endtask

  task automatic exp_bits(input int k0, input logic [15:0] d, input int nb);
    for (int i = 0; i < nb; i++) mq.push_back('{k0 + i, 16'h0, 16'(d[15-i])});
  endtask

  initial begin : stim
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h05] = 16'hC3A5;
    mem[8'hFF] = 16'h8001;
    mem[8'h00] = 16'h7FFE;

    repeat (3) @(negedge SCLK);
    #2;
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_wdata", 32'(reg_write_data), 32'h0);
    chk("rst_wen", 32'(reg_write_enable), 32'h0);
    chk("rst_ren", 32'(reg_read_enable), 32'h0);
    chk("rst_abort", 32'(frame_abort), 32'h0);
    chk("rst_miso", 32'(MISO), 32'h0);
    chk("rst_miso_en", 32'(MISO_enable), 32'h0);
    @(negedge SCLK);
    rst_n = 1'b1;

    // Single write
    wq.push_back('{26, 16'h3C, 16'hA55A});
    wr_frame(1'b0, 8'h3C, {16'hA55A, 32'h0}, 16);

    // Burst write with address wrap
    wq.push_back('{26, 16'hFE, 16'h1111});
    wq.push_back('{42, 16'hFF, 16'h2222});
    wq.push_back('{58, 16'h00, 16'h3333});
    wr_frame(1'b1, 8'hFE, {16'h1111, 16'h2222, 16'h3333}, 48);

    // Single read: data from k=12, prefetch at k=26
    rq.push_back('{10, 16'h10, 16'h0});
    rq.push_back('{26, 16'h10, 16'h0});
    exp_bits(12, 16'hBEEF, 16);
    rd_frame(1'b0, 8'h10, 2 + 16);

    // Burst read, fixed address
    rq.push_back('{10, 16'h05, 16'h0});
    rq.push_back('{26, 16'h05, 16'h0});
    rq.push_back('{42, 16'h05, 16'h0});
    exp_bits(12, 16'hC3A5, 16);
    exp_bits(28, 16'hC3A5, 16);
    rd_frame(1'b0, 8'h05, 2 + 32);

    // Burst read, incrementing across the wrap
    rq.push_back('{10, 16'hFF, 16'h0});
    rq.push_back('{26, 16'h00, 16'h0});
    rq.push_back('{42, 16'h01, 16'h0});
    exp_bits(12, 16'h8001, 16);
    exp_bits(28, 16'h7FFE, 16);
    rd_frame(1'b1, 8'hFF, 2 + 32);

    // Deselect during the address
    aq.push_back(6);
    bit_out(1'b1, 0);
    bit_out(1'b0, 1);
    bit_out(1'b1, 2);
    bit_out(1'b0, 3);
    bit_out(1'b1, 4);
    stop(5);

    // Deselect after 9 write data bits, then a clean frame
    aq.push_back(20);
    wr_frame(1'b0, 8'h3C, {16'hA5C3, 32'h0}, 9);
    wq.push_back('{26, 16'h22, 16'h0F0F});
    wr_frame(1'b0, 8'h22, {16'h0F0F, 32'h0}, 16);

    // Reset in the middle of a read word
    rq.push_back('{10, 16'h10, 16'h0});
    exp_bits(12, 16'hBEEF, 5);
    hdr(1'b0, 1'b0, 8'h10);
    for (int k = 10; k < 16; k++) bit_out(1'b0, k);
    @(negedge SCLK);
    rst_n = 1'b0;
    frame_k = 16;
    @(posedge SCLK);
    @(negedge SCLK);
    CSN = 1'b1;
    frame_k = 17;
    #2;
    chk("mid_rst_miso_en", 32'(MISO_enable), 32'h0);
    chk("mid_rst_miso", 32'(MISO), 32'h0);
    chk("mid_rst_addr", 32'(reg_addr), 32'h0);
    chk("mid_rst_wdata", 32'(reg_write_data), 32'h0);
    chk("mid_rst_wen", 32'(reg_write_enable), 32'h0);
    chk("mid_rst_ren", 32'(reg_read_enable), 32'h0);
    chk("mid_rst_abort", 32'(frame_abort), 32'h0);
    @(negedge SCLK);
    rst_n = 1'b1;

    // Recovery frame after reset
    wq.push_back('{26, 16'h7E, 16'h1234});
    wr_frame(1'b0, 8'h7E, {16'h1234, 32'h0}, 16);

    repeat (4) @(negedge SCLK);
    #2;
    chk("wq_drain", wq.size(), 0);
    chk("rq_drain", rq.size(), 0);
    chk("mq_drain", mq.size(), 0);
    chk("aq_drain", aq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_burst_slave.md
SPI_BURST_SLAVE -- requirements
Module: spi_burst_slave

Interface
REQ-001 Parameter ADDR_W, default 8, register address width in bits (1..16).
REQ-002 Parameter DATA_W, default 16, register data word width in bits (8..32).
REQ-003 Parameter DUMMY_CYC, default 2, read turnaround SCLK cycles between address and first read bit (1..7).
REQ-004 SCLK  input  1  sole clock; MOSI sampled on rising edge, MISO/MISO_enable launched on falling edge.
REQ-005 rst_n  input  1  reset, synchronous to SCLK rising edge, active-low.
REQ-006 CSN  input  1  active-low chip select; frame spans the SCLK rising edges sampled with CSN=0.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 reg_read_data  input  DATA_W  register file read data, valid the cycle after reg_read_enable.
REQ-009 MISO  output  1  serial read data, MSB first.
REQ-010 MISO_enable  output  1  high while MISO carries read data bits.
REQ-011 reg_addr  output  ADDR_W  current register address.
REQ-012 reg_write_data  output  DATA_W  last completed write word.
REQ-013 reg_write_enable  output  1  one-cycle write strobe.
REQ-014 reg_read_enable  output  1  one-cycle read strobe.
REQ-015 frame_abort  output  1  one-cycle pulse on a frame ending mid-word.

Function
REQ-016 Frame format, rising-edge index k from 0: k=0 RW (1=write, 0=read); k=1 INC (1=auto-increment); k=2..ADDR_W+1 address, MSB first; then data words.
REQ-017 FSM states: IDLE, CMD, ADDR, TURN, WDATA, RDATA; IDLE->CMD on the first edge with CSN=0, which samples bit k=0 (no lost cycle).
REQ-018 At edge k=ADDR_W+1: reg_addr is loaded; write -> WDATA; read -> TURN with reg_read_enable=1 for one cycle.
REQ-019 WDATA: DATA_W bits are shifted in; on the edge sampling the last bit, reg_write_data is loaded and reg_write_enable=1 for the following cycle, paired with the current reg_addr.
REQ-020 Burst: WDATA/RDATA continue back-to-back with no gap while CSN=0.
REQ-021 Burst addressing: with INC=1, reg_addr increments by 1 modulo 2^ADDR_W per completed word (0xFF->0x00 for ADDR_W=8); with INC=0, reg_addr holds.
REQ-022 The increment in REQ-021 takes effect in the same cycle as that word's write strobe or the next word's read strobe.
REQ-023 Read timing: reg_read_data is captured into the TX shifter one edge after reg_read_enable; the first data bit is valid on MISO from the falling edge preceding rising edge k=ADDR_W+2+DUMMY_CYC.
REQ-024 MISO_enable is high exactly for the DATA_W bit periods of each read word; MISO=0 whenever MISO_enable=0.
REQ-025 Read prefetch: the next word's reg_read_enable is issued 2 edges before the current word's last bit, so the next word follows without gap.
REQ-026 Any rising edge with CSN=1: FSM -> IDLE, bit/word counters cleared, no strobes, MISO_enable=0 from the next falling edge.
REQ-027 frame_abort=1 for one cycle if the CSN=1 edge finds CMD, ADDR, TURN, or a partial WDATA/RDATA word; no write strobe for a partial word.
REQ-028 CSN high exactly on a word boundary is a clean end: frame_abort=0.
REQ-029 Strobes are mutually exclusive; reg_write_enable and reg_read_enable are never high together.

Reset
REQ-030 rst_n=0 at a rising edge: FSM=IDLE, counters=0, reg_addr=0, reg_write_data=0, all strobes=0, frame_abort=0.
REQ-031 The next falling edge after reset forces MISO=0 and MISO_enable=0.
REQ-032 Reset overrides CSN and any in-progress frame.
REQ-033 Reset mid-write: no reg_write_enable.

Structure
REQ-034 Shared package spi_pkg holds the FSM state encoding, the bit positions of RW and INC, and parameter range limits.
REQ-035 One sub-module, spi_shift_tx: DATA_W parallel-load, MSB-first shifter with negedge launch stage driving MISO/MISO_enable.

Verification (ADDR_W=8, DATA_W=16, DUMMY_CYC=2)
REQ-036 Single write RW=1 INC=0 addr 0x3C data 0xA55A -> one reg_write_enable with reg_addr=0x3C, reg_write_data=0xA55A; frame_abort=0.
REQ-037 Burst write INC=1 addr 0xFE, 3 words 0x1111/0x2222/0x3333 -> strobes at addrs 0xFE, 0xFF, 0x00 with matching data, no gaps.
REQ-038 Single read addr 0x10, model returns 0xBEEF -> reg_read_enable once; MISO shifts 1011111011101111 starting at edge k=12; MISO_enable high 16 bits.
REQ-039 Burst read INC=0 addr 0x05, 2 words -> two reg_read_enable pulses at addr 0x05; 32 contiguous MISO bits.
REQ-040 CSN raised after 9 write data bits -> frame_abort pulse, no reg_write_enable; next frame decodes correctly.
REQ-041 rst_n low mid-read-word -> MISO_enable=0 next falling edge, all outputs at reset values.
